pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard and forwarding controller for the 5-stage RISC-V CPU/FPU pipeline.
//  Drives the stall/flush/enable inputs of the F/D, D/E and E/M pipeline registers.
//  Generates the E-stage operand forwarding selects.
//  Sequences multi-cycle FPU ops held in E through a latency counter FSM.
// PARAMETERS
//  FP_LAT    4       cycles an FPU op occupies E (legal range 2..15)
//  LOAD_SEL  3'b001  result_srcE encoding that marks a load
// PORTS
//  clk          in   1  pipeline clock; all state updates on posedge
//  reset        in   1  asynchronous, active-low reset
//  rs1D,rs2D    in   5  source registers of instruction in D
//  rs1E,rs2E    in   5  source registers of instruction in E
//  rdE,rdM,rdW  in   5  destination registers in E/M/W
//  Reg_writeM   in   1  M-stage instruction writes rdM
//  Reg_writeW   in   1  W-stage instruction writes rdW
//  result_srcE  in   3  E-stage result select; ==LOAD_SEL means load
//  PC_srcE      in   1  taken branch/jump resolved in E
//  float_ctrlE  in   1  E holds a multi-cycle FPU op
//  stall_f      out  1  hold PC
//  stall_d      out  1  hold F/D register
//  stall_e      out  1  hold D/E register contents
//  flush_d      out  1  clear F/D register
//  flush_e      out  1  clear D/E register (bubble)
//  flush_m      out  1  clear E/M register (bubble)
//  fwd_a_e      out  2  operand A select: 00 reg, 01 W result, 10 M result
//  fwd_b_e      out  2  operand B select, same encoding
//  fpu_done     out  1  one-cycle pulse: FPU op completes this cycle
// BEHAVIOUR
//  Outputs are combinational from FSM state and inputs.
//  While reset=0, state=IDLE, cnt=0, and every output is forced to 0.
//  Forwarding, per operand X in {1,2} (A uses rs1E, B uses rs2E):
//   10 if Reg_writeM & rdM!=0 & rdM==rsXE
//   else 01 if Reg_writeW & rdW!=0 & rdW==rsXE
//   else 00.  M has priority over W.  x0 is never forwarded.
//  lw_stall = IDLE & result_srcE==LOAD_SEL & rdE!=0 & (rdE==rs1D | rdE==rs2D).
//  FSM states: IDLE, BUSY; 4-bit cnt.
//  IDLE:
//   - PC_srcE=1: flush_d=1, flush_e=1; no stalls; stay IDLE.
//     Branch has priority; float_ctrlE is ignored this cycle.
//   - else if float_ctrlE=1: stall_f=stall_d=stall_e=1, flush_m=1;
//     next state BUSY, cnt<=FP_LAT-2.
//   - else if lw_stall: stall_f=stall_d=1, flush_e=1 (one-cycle bubble).
//   - else all stall/flush outputs 0.
//  BUSY:
//   - cnt!=0: stall_f=stall_d=stall_e=1, flush_m=1, cnt<=cnt-1.
//   - cnt==0: no stall/flush; fpu_done=1; next state IDLE.
//     The E result advances to M on this edge.
//  Timing: an FPU op stays in E for exactly FP_LAT cycles.
//   Stalls are asserted for FP_LAT-1 cycles.
//   fpu_done asserts on the FP_LAT-th cycle.
//  In BUSY, PC_srcE, lw_stall and float_ctrlE are ignored.
//   The re-presented op in E must not retrigger the FSM.
//  Forwarding stays active in BUSY, so W/M writebacks still reach the held op.
//  Reset asserted mid-op: immediate return to IDLE, cnt=0, op abandoned.
//   No fpu_done is generated.
//  Back-to-back FPU ops: IDLE sees the next float_ctrlE the cycle after
//   fpu_done, so the FSM re-enters BUSY with no gap cycle lost.
// TESTING
//  1 rdM=5,Reg_writeM=1,rs1E=5; rdW=5,Reg_writeW=1 -> fwd_a_e=10 (M wins).
//    With rdM=0 instead -> fwd_a_e=01.
//  2 load in E (result_srcE=001, rdE=7), rs2D=7 -> stall_f=stall_d=flush_e=1 one cycle.
//    With rdE=0 -> no stall.
//  3 PC_srcE=1 together with float_ctrlE=1 in IDLE -> flush_d=flush_e=1.
//    FSM stays IDLE; no stall_e.
//  4 FP_LAT=4, float_ctrlE=1 -> stall_e/flush_m high 3 cycles.
//    fpu_done pulses on cycle 4, then IDLE.
//  5 reset low during BUSY cycle 2 -> all outputs 0 at once.
//    After release: IDLE, no fpu_done.
//  6 two consecutive FPU ops, FP_LAT=2 -> stall pattern 1,0,1,0.
//    fpu_done pulses on cycles 2 and 4.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage CPU/FPU pipeline; outputs are combinational from state and inputs.
// A multi-cycle FPU op holds F/D/E for FP_LAT-1 cycles, then pulses fpu_done as it moves to M.
module pipe_hazard_ctrl #(
    parameter int unsigned FP_LAT   = 4,
    parameter logic [2:0]  LOAD_SEL = 3'b001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1D,
    input  logic [4:0] rs2D,
    input  logic [4:0] rs1E,
    input  logic [4:0] rs2E,
    input  logic [4:0] rdE,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       Reg_writeM,
    input  logic       Reg_writeW,
    input  logic [2:0] result_srcE,
    input  logic       PC_srcE,
    input  logic       float_ctrlE,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
    output logic       fpu_done
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The trigger cycle is the first of the FP_LAT cycles, and the cnt==0 cycle is the last.
    localparam logic [3:0] CNT_INIT = 4'(FP_LAT - 2);

    state_t     state;
    logic [3:0] cnt;
    logic       lw_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    always_comb begin
        lw_stall = (state == IDLE) && (result_srcE == LOAD_SEL) && (rdE != 5'd0) &&
                   ((rdE == rs1D) || (rdE == rs2D));
    end

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        fwd_a_e  = 2'b00;
        fwd_b_e  = 2'b00;
        fpu_done = 1'b0;
        if (reset) begin
            // Forwarding stays live while BUSY so late writebacks reach the held op.
            fwd_a_e = fwd_sel(rs1E, Reg_writeM, rdM, Reg_writeW, rdW);
            fwd_b_e = fwd_sel(rs2E, Reg_writeM, rdM, Reg_writeW, rdW);
            case (state)
                IDLE: begin
                    if (PC_srcE) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (float_ctrlE) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                    end else if (lw_stall) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                    end else begin
                        fpu_done = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!PC_srcE && float_ctrlE) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    // float_ctrlE stays high for the held op; it must not retrigger here.
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
